// File: rtl/video_timing_analyzer_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared types and constants for the video timing analyzer.
//   state_t      : analyzer state (SEEK waits for a frame start, MEAS measures)
//   ERR_*        : bit positions inside err_flags
//   DEF_HACT/VACT: default active geometry (640x480)
// ---------------------------------------------------------------------------
package video_timing_pkg;

    typedef enum logic {
        SEEK = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam int ERR_HACT  = 0;
    localparam int ERR_VACT  = 1;
    localparam int ERR_STRAY = 2;
    localparam int ERR_HTOT  = 3;

    localparam int DEF_HACT = 640;
    localparam int DEF_VACT = 480;

endpackage

// File: rtl/video_timing_analyzer_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// One-cycle delay register with rise/fall detection against the live input.
//   clk     : clock
//   rst_n   : synchronous active-low reset
//   sig_i   : sampled input
//   rise_o  : sig_i & ~previous sample
//   fall_o  : ~sig_i & previous sample
// RST_VAL sets the delayed value after reset; a value of 1 keeps a level that
// is already high at reset release from looking like a fresh rising edge.
// ---------------------------------------------------------------------------
module sync_edge_det #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/video_timing_analyzer.sv
// ---------------------------------------------------------------------------
// video_timing_analyzer
// Sink-side checker for a parallel RGB888 video stream. Measures line and
// frame geometry, compares it with the expected active size and reports a
// per-frame verdict plus a lock indication.
//
// Ports:
//   px_clk, sys_rst_n           : pixel clock, synchronous active-low reset
//   vsync_i / hsync_i / dval_i  : frame window, line window, pixel valid
//   rdata_i / gdata_i / bdata_i : 8-bit pixel components
//   frame_done                  : one-cycle pulse when a frame is evaluated
//   frame_ok / err_flags        : verdict and error bits of the last frame
//   locked                      : LOCK_FRAMES consecutive good frames seen
//   meas_hact / meas_vact       : last closed line length / last frame lines
//   meas_htotal                 : clocks between the two latest hsync rises
//   frame_cnt                   : completed frames (wraps)
//   meas_csum                   : frame pixel checksum
//
// Optional feature: define VIDEO_TIMING_ANALYZER_CSUM_EN to build the 32-bit
// pixel checksum accumulator; without it meas_csum is constant zero.
// ---------------------------------------------------------------------------
module video_timing_analyzer
    import video_timing_pkg::*;
#(
    parameter int EXP_HACT    = DEF_HACT,
    parameter int EXP_VACT    = DEF_VACT,
    parameter int LOCK_FRAMES = 3,
    parameter int CW          = 16
) (
    input  logic          px_clk,
    input  logic          sys_rst_n,
    input  logic          vsync_i,
    input  logic          hsync_i,
    input  logic          dval_i,
    input  logic [7:0]    rdata_i,
    input  logic [7:0]    gdata_i,
    input  logic [7:0]    bdata_i,
    output logic          frame_done,
    output logic          frame_ok,
    output logic          locked,
    output logic [3:0]    err_flags,
    output logic [CW-1:0] meas_hact,
    output logic [CW-1:0] meas_vact,
    output logic [CW-1:0] meas_htotal,
    output logic [CW-1:0] frame_cnt,
    output logic [31:0]   meas_csum
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    logic vsync_rise, vsync_fall, hsync_rise, dval_fall;
    logic hsync_fall_unused, dval_rise_unused;

    sync_edge_det #(.RST_VAL(1'b1)) u_vsync_edge (
        .clk(px_clk), .rst_n(sys_rst_n), .sig_i(vsync_i),
        .rise_o(vsync_rise), .fall_o(vsync_fall)
    );

    sync_edge_det #(.RST_VAL(1'b1)) u_hsync_edge (
        .clk(px_clk), .rst_n(sys_rst_n), .sig_i(hsync_i),
        .rise_o(hsync_rise), .fall_o(hsync_fall_unused)
    );

    sync_edge_det #(.RST_VAL(1'b0)) u_dval_edge (
        .clk(px_clk), .rst_n(sys_rst_n), .sig_i(dval_i),
        .rise_o(dval_rise_unused), .fall_o(dval_fall)
    );

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CW-1:0] line_cnt_q, line_cnt_d;
    logic [CW-1:0] htot_cnt_q, htot_cnt_d;
    logic          hact_err_q, hact_err_d;
    logic          stray_err_q, stray_err_d;
    logic          htot_err_q, htot_err_d;
    logic          seen_hrise_q, seen_hrise_d;
    logic          have_htot_q, have_htot_d;
    logic [3:0]    good_cnt_q, good_cnt_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_ok_q, frame_ok_d;
    logic          locked_q, locked_d;
    logic [3:0]    err_flags_q, err_flags_d;
    logic [CW-1:0] meas_hact_q, meas_hact_d;
    logic [CW-1:0] meas_vact_q, meas_vact_d;
    logic [CW-1:0] meas_htotal_q, meas_htotal_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;

    logic          active;
    logic          eval;
    logic          close_line;
    logic [3:0]    err_now;
    logic [3:0]    good_next;

    // Measurement only happens inside the vsync window; the frame is judged on
    // the vsync fall, which also closes a line still open at that moment.
    assign active = (state_q == MEAS) && vsync_i;
    assign eval   = (state_q == MEAS) && vsync_fall;

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        hact_err_d    = hact_err_q;
        stray_err_d   = stray_err_q;
        htot_err_d    = htot_err_q;
        seen_hrise_d  = seen_hrise_q;
        have_htot_d   = have_htot_q;
        good_cnt_d    = good_cnt_q;
        frame_done_d  = 1'b0;
        frame_ok_d    = frame_ok_q;
        locked_d      = locked_q;
        err_flags_d   = err_flags_q;
        meas_hact_d   = meas_hact_q;
        meas_vact_d   = meas_vact_q;
        meas_htotal_d = meas_htotal_q;
        frame_cnt_d   = frame_cnt_q;
        err_now       = 4'b0000;
        good_next     = 4'd0;
        close_line    = active ? dval_fall : (eval && (pix_cnt_q != '0));

        if ((state_q == SEEK) && vsync_rise) begin
            state_d = MEAS;
        end

        if (active && dval_i) begin
            pix_cnt_d = sat_inc(pix_cnt_q);
        end

        // A saturated count can never equal a real geometry, so it is always
        // reported as a mismatch.
        if (close_line) begin
            meas_hact_d = pix_cnt_q;
            pix_cnt_d   = '0;
            line_cnt_d  = sat_inc(line_cnt_q);
            if ((pix_cnt_q != CW'(EXP_HACT)) || (&pix_cnt_q)) begin
                hact_err_d = 1'b1;
            end
        end

        // Free-running line period counter; it restarts at 1 on each hsync
        // rise so that its value at the next rise equals the period.
        htot_cnt_d = hsync_rise ? CW'(1) : sat_inc(htot_cnt_q);

        if (active && hsync_rise) begin
            if (seen_hrise_q) begin
                meas_htotal_d = htot_cnt_q;
                if (have_htot_q && (htot_cnt_q != meas_htotal_q)) begin
                    htot_err_d = 1'b1;
                end
                have_htot_d = 1'b1;
            end
            seen_hrise_d = 1'b1;
        end

        if (dval_i && !vsync_i) begin
            stray_err_d = 1'b1;
        end

        if (eval) begin
            err_now[ERR_HACT]  = hact_err_d;
            err_now[ERR_VACT]  = (line_cnt_d != CW'(EXP_VACT)) || (&line_cnt_d);
            err_now[ERR_STRAY] = stray_err_d;
            err_now[ERR_HTOT]  = htot_err_d;
            if (err_now == 4'b0000) begin
                good_next = (good_cnt_q >= LOCK_N) ? LOCK_N : good_cnt_q + 4'd1;
            end
            err_flags_d  = err_now;
            frame_ok_d   = (err_now == 4'b0000);
            meas_vact_d  = line_cnt_d;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CW'(1);
            good_cnt_d   = good_next;
            locked_d     = (good_next == LOCK_N);
            pix_cnt_d    = '0;
            line_cnt_d   = '0;
            hact_err_d   = 1'b0;
            stray_err_d  = 1'b0;
            htot_err_d   = 1'b0;
            seen_hrise_d = 1'b0;
            have_htot_d  = 1'b0;
        end
    end

    always_ff @(posedge px_clk) begin
        if (!sys_rst_n) begin
            state_q       <= SEEK;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            htot_cnt_q    <= '0;
            hact_err_q    <= 1'b0;
            stray_err_q   <= 1'b0;
            htot_err_q    <= 1'b0;
            seen_hrise_q  <= 1'b0;
            have_htot_q   <= 1'b0;
            good_cnt_q    <= 4'd0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            locked_q      <= 1'b0;
            err_flags_q   <= 4'b0000;
            meas_hact_q   <= '0;
            meas_vact_q   <= '0;
            meas_htotal_q <= '0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            htot_cnt_q    <= htot_cnt_d;
            hact_err_q    <= hact_err_d;
            stray_err_q   <= stray_err_d;
            htot_err_q    <= htot_err_d;
            seen_hrise_q  <= seen_hrise_d;
            have_htot_q   <= have_htot_d;
            good_cnt_q    <= good_cnt_d;
            frame_done_q  <= frame_done_d;
            frame_ok_q    <= frame_ok_d;
            locked_q      <= locked_d;
            err_flags_q   <= err_flags_d;
            meas_hact_q   <= meas_hact_d;
            meas_vact_q   <= meas_vact_d;
            meas_htotal_q <= meas_htotal_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_ok    = frame_ok_q;
    assign locked      = locked_q;
    assign err_flags   = err_flags_q;
    assign meas_hact   = meas_hact_q;
    assign meas_vact   = meas_vact_q;
    assign meas_htotal = meas_htotal_q;
    assign frame_cnt   = frame_cnt_q;

`ifdef VIDEO_TIMING_ANALYZER_CSUM_EN
    logic [31:0] csum_acc_q, csum_acc_d;
    logic [31:0] meas_csum_q, meas_csum_d;

    // Sum of all components of every valid pixel in the frame, mod 2^32.
    always_comb begin
        csum_acc_d  = csum_acc_q;
        meas_csum_d = meas_csum_q;
        if (active && dval_i) begin
            csum_acc_d = csum_acc_q + 32'(rdata_i) + 32'(gdata_i) + 32'(bdata_i);
        end
        if (eval) begin
            meas_csum_d = csum_acc_d;
            csum_acc_d  = '0;
        end
    end

    always_ff @(posedge px_clk) begin
        if (!sys_rst_n) begin
            csum_acc_q  <= '0;
            meas_csum_q <= '0;
        end else begin
            csum_acc_q  <= csum_acc_d;
            meas_csum_q <= meas_csum_d;
        end
    end

    assign meas_csum = meas_csum_q;
`else
    logic unused_px;
    assign unused_px = ^{rdata_i, gdata_i, bdata_i};
    assign meas_csum = '0;
`endif

endmodule

// File: tb/tb_video_timing_analyzer.sv
// ---------------------------------------------------------------------------
// tb_video_timing_analyzer
// Drives whole frames described as per-line pixel counts and line periods,
// predicts each frame's report from that description, and compares the DUT
// report at every frame_done. Small geometry (16x6, period 24) keeps runs short.
// ---------------------------------------------------------------------------
module tb_video_timing_analyzer;

    localparam int HACT  = 16;
    localparam int VACT  = 6;
    localparam int LOCKN = 3;
    localparam int CW    = 16;
    localparam int HTOT  = 24;

    logic          px_clk    = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          vsync_i   = 1'b0;
    logic          hsync_i   = 1'b0;
    logic          dval_i    = 1'b0;
    logic [7:0]    rdata_i   = 8'd0;
    logic [7:0]    gdata_i   = 8'd0;
    logic [7:0]    bdata_i   = 8'd0;
    logic          frame_done, frame_ok, locked;
    logic [3:0]    err_flags;
    logic [CW-1:0] meas_hact, meas_vact, meas_htotal, frame_cnt;
    logic [31:0]   meas_csum;

    video_timing_analyzer #(
        .EXP_HACT(HACT), .EXP_VACT(VACT), .LOCK_FRAMES(LOCKN), .CW(CW)
    ) dut (
        .px_clk(px_clk), .sys_rst_n(sys_rst_n),
        .vsync_i(vsync_i), .hsync_i(hsync_i), .dval_i(dval_i),
        .rdata_i(rdata_i), .gdata_i(gdata_i), .bdata_i(bdata_i),
        .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked),
        .err_flags(err_flags), .meas_hact(meas_hact), .meas_vact(meas_vact),
        .meas_htotal(meas_htotal), .frame_cnt(frame_cnt), .meas_csum(meas_csum)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        int         due;
        bit         ok;
        logic [3:0] err;
        int         hact;
        int         vact;
        int         htot;
        int         fcnt;
        bit         lck;
        longint     csum;
    } exp_t;

    exp_t   expq[$];
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    int     m_good = 0, m_fcnt = 0, m_hact = 0, m_htot = 0;
    bit     m_stray = 1'b0;
    bit     aborted = 1'b0;
    longint m_csum = 0;
    int     rst_hold = 0;
    int     lpix[16];
    int     lper[16];

    always @(posedge px_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Compare process: frame_done must pulse exactly when predicted, and the
    // report fields must match the prediction for that frame.
    always @(negedge px_clk) begin : compare_proc
        exp_t e;
        bit   due_now;
        due_now = (expq.size() > 0) && (expq[0].due == cyc);
        checkOutput("frame_done_timing", longint'(frame_done), longint'(due_now));
        if (due_now) begin
            e = expq.pop_front();
            checkOutput("frame_ok",    longint'(frame_ok),    longint'(e.ok));
            checkOutput("err_flags",   longint'(err_flags),   longint'(e.err));
            checkOutput("meas_hact",   longint'(meas_hact),   longint'(e.hact));
            checkOutput("meas_vact",   longint'(meas_vact),   longint'(e.vact));
            checkOutput("meas_htotal", longint'(meas_htotal), longint'(e.htot));
            checkOutput("frame_cnt",   longint'(frame_cnt),   longint'(e.fcnt));
            checkOutput("locked",      longint'(locked),      longint'(e.lck));
            checkOutput("meas_csum",   longint'(meas_csum),   e.csum);
        end
    end

    task automatic resetModel();
        m_good  = 0;
        m_fcnt  = 0;
        m_hact  = 0;
        m_htot  = 0;
        m_stray = 1'b0;
    endtask

    // One clock of input drive, applied on the falling edge.
    task automatic drive(input logic v, input logic h, input logic d, input bit const_px);
        @(negedge px_clk);
        if (rst_hold > 0) begin
            sys_rst_n = 1'b0;
            rst_hold--;
        end else begin
            sys_rst_n = 1'b1;
        end
        vsync_i = v;
        hsync_i = h;
        dval_i  = d;
        if (d) begin
            rdata_i = const_px ? 8'd1 : 8'($urandom_range(255));
            gdata_i = const_px ? 8'd2 : 8'($urandom_range(255));
            bdata_i = const_px ? 8'd3 : 8'($urandom_range(255));
        end else begin
            rdata_i = 8'd0;
            gdata_i = 8'd0;
            bdata_i = 8'd0;
        end
        if (d && !v) m_stray = 1'b1;
        if (d && v && !aborted) m_csum += longint'(rdata_i) + longint'(gdata_i) + longint'(bdata_i);
    endtask

    task automatic setNominal();
        for (int i = 0; i < 16; i++) begin
            lpix[i] = HACT;
            lper[i] = HTOT;
        end
    endtask

    // Plays one frame from lpix/lper, then blanking with optional stray dval.
    // rst_line >= 0 pulses reset at the start of that line and discards the frame.
    task automatic applyStimulus(input int nlines, input int nstray, input bit const_px, input int rst_line);
        exp_t e;
        bit   hact_e, htot_e;
        m_csum  = 0;
        aborted = 1'b0;
        drive(1'b1, 1'b0, 1'b0, const_px);
        for (int i = 0; i < nlines; i++) begin
            if (i == rst_line) begin
                rst_hold = 3;
                aborted  = 1'b1;
                resetModel();
            end
            for (int c = 0; c < lper[i]; c++) begin
                drive(1'b1, c < 4, (c >= 4) && (c < 4 + lpix[i]), const_px);
            end
            if (i == rst_line) begin
                checkOutput("post_reset_frame_cnt", longint'(frame_cnt), 0);
                checkOutput("post_reset_locked",    longint'(locked),    0);
                checkOutput("post_reset_meas_hact", longint'(meas_hact), 0);
                checkOutput("post_reset_err_flags", longint'(err_flags), 0);
            end
        end
        drive(1'b0, 1'b0, 1'b0, const_px);
        if (!aborted) begin
            hact_e = 1'b0;
            htot_e = 1'b0;
            for (int i = 0; i < nlines; i++) if (lpix[i] != HACT) hact_e = 1'b1;
            for (int i = 1; i <= nlines - 2; i++) if (lper[i] != lper[0]) htot_e = 1'b1;
            if (nlines >= 1) m_hact = lpix[nlines-1];
            if (nlines >= 2) m_htot = lper[nlines-2];
            e.due  = cyc + 1;
            e.err  = {htot_e, m_stray, (nlines != VACT), hact_e};
            e.ok   = (e.err == 4'b0000);
            m_good = e.ok ? ((m_good < LOCKN) ? m_good + 1 : LOCKN) : 0;
            m_fcnt = (m_fcnt + 1) % 65536;
            e.hact = m_hact;
            e.vact = nlines;
            e.htot = m_htot;
            e.fcnt = m_fcnt;
            e.lck  = (m_good == LOCKN);
`ifdef VIDEO_TIMING_ANALYZER_CSUM_EN
            e.csum = m_csum & 64'hFFFF_FFFF;
`else
            e.csum = 0;
`endif
            m_stray = 1'b0;
            expq.push_back(e);
        end
        for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 1'b0, const_px);
        for (int c = 0; c < nstray; c++) drive(1'b0, 1'b0, 1'b1, const_px);
        for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 1'b0, const_px);
    endtask

    initial begin
        int nl;
        int ns;
        rst_hold = 5;
        for (int c = 0; c < 8; c++) drive(1'b0, 1'b0, 1'b0, 1'b0);

        checkOutput("reset_frame_ok",   longint'(frame_ok),    0);
        checkOutput("reset_locked",     longint'(locked),      0);
        checkOutput("reset_err_flags",  longint'(err_flags),   0);
        checkOutput("reset_meas_hact",  longint'(meas_hact),   0);
        checkOutput("reset_meas_vact",  longint'(meas_vact),   0);
        checkOutput("reset_meas_htot",  longint'(meas_htotal), 0);
        checkOutput("reset_frame_cnt",  longint'(frame_cnt),   0);
        checkOutput("reset_meas_csum",  longint'(meas_csum),   0);

        // Nominal frames, the first with constant r=1 g=2 b=3 pixels.
        setNominal();
        applyStimulus(VACT, 0, 1'b1, -1);
`ifdef VIDEO_TIMING_ANALYZER_CSUM_EN
        checkOutput("lit_csum_const", longint'(meas_csum), 576);
`else
        checkOutput("lit_csum_const", longint'(meas_csum), 0);
`endif
        checkOutput("lit_locked_f1", longint'(locked), 0);
        applyStimulus(VACT, 0, 1'b0, -1);
        applyStimulus(VACT, 0, 1'b0, -1);
        checkOutput("lit_locked_f3", longint'(locked),      1);
        checkOutput("lit_fcnt_f3",   longint'(frame_cnt),   3);
        checkOutput("lit_hact_f3",   longint'(meas_hact),   16);
        checkOutput("lit_vact_f3",   longint'(meas_vact),   6);
        checkOutput("lit_htot_f3",   longint'(meas_htotal), 24);
        checkOutput("lit_ok_f3",     longint'(frame_ok),    1);

        // Short line.
        setNominal();
        lpix[2] = HACT - 1;
        applyStimulus(VACT, 0, 1'b0, -1);
        checkOutput("lit_short_err",    longint'(err_flags), 1);
        checkOutput("lit_short_ok",     longint'(frame_ok),  0);
        checkOutput("lit_short_locked", longint'(locked),    0);
        setNominal();
        applyStimulus(VACT, 0, 1'b0, -1);
        checkOutput("lit_relock_locked", longint'(locked), 0);

        // Missing line.
        applyStimulus(VACT - 1, 0, 1'b0, -1);
        checkOutput("lit_missing_err",  longint'(err_flags), 2);
        checkOutput("lit_missing_vact", longint'(meas_vact), 5);

        // Stray dval in blanking is reported with the following frame.
        applyStimulus(VACT, 5, 1'b0, -1);
        checkOutput("lit_stray_pre", longint'(err_flags), 0);
        applyStimulus(VACT, 0, 1'b0, -1);
        checkOutput("lit_stray_err", longint'(err_flags), 4);

        // Line period changes inside a frame.
        lper[3] = HTOT + 1;
        applyStimulus(VACT, 0, 1'b0, -1);
        checkOutput("lit_htot_err", longint'(err_flags), 8);
        setNominal();

        // Reset in the middle of a frame with vsync still high at release.
        applyStimulus(VACT, 0, 1'b0, 3);
        applyStimulus(VACT, 0, 1'b0, -1);
        checkOutput("lit_after_rst_fcnt", longint'(frame_cnt), 1);
        checkOutput("lit_after_rst_vact", longint'(meas_vact), 6);
        checkOutput("lit_after_rst_ok",   longint'(frame_ok),  1);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            setNominal();
            nl = VACT;
            if ($urandom_range(9) < 2) nl = ($urandom_range(1) == 0) ? VACT - 1 : VACT + 1;
            for (int i = 0; i < nl; i++) begin
                if ($urandom_range(14) == 0) lpix[i] = ($urandom_range(1) == 0) ? HACT - 1 : HACT + 1;
                if ($urandom_range(11) == 0) lper[i] = HTOT + 1;
            end
            ns = ($urandom_range(4) == 0) ? int'($urandom_range(3, 1)) : 0;
            applyStimulus(nl, ns, 1'b0, -1);
        end

        for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pending_frames", longint'(expq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timing_analyzer.md
Name: video_timing_analyzer

Overview:
- Sink-side checker for the parallel RGB888 video interface driven by the pattern/timing sources (vsync/hsync/dval plus 8-bit R/G/B).
- Measures line/frame geometry, checks it against expected active size, and reports per-frame results and a lock status.
- Sits at the receive end of the video path, for bring-up and self-test.

Parameters:
- EXP_HACT, 640, expected dval-high pixels per active line
- EXP_VACT, 480, expected active lines per frame
- LOCK_FRAMES, 3, consecutive good frames required to assert locked (1..15)
- CW, 16, width of all measurement counters

Ports:
- px_clk  in  1  pixel clock
- sys_rst_n  in  1  reset, active-low
- vsync_i  in  1  high = frame active window
- hsync_i  in  1  high = line window; rising edge starts a line period
- dval_i  in  1  pixel valid
- rdata_i / gdata_i / bdata_i  in  8 each  pixel data
- frame_done  out  1  one-cycle pulse at frame end
- frame_ok  out  1  result of last completed frame
- locked  out  1  LOCK_FRAMES consecutive good frames
- err_flags  out  4  [0] hact mismatch, [1] vact mismatch, [2] stray dval, [3] htotal unstable
- meas_hact  out  CW  pixel count of last closed line
- meas_vact  out  CW  active lines in last frame
- meas_htotal  out  CW  clocks between the last two hsync rises
- frame_cnt  out  CW  completed frames, wraps
- meas_csum  out  32  frame pixel checksum (optional feature)

Behaviour:
- Reset is synchronous and active-low (sys_rst_n), on the single clock px_clk.
- In reset: all outputs 0, all counters 0, state SEEK.
- Edge-detect registers:
  - vsync_d and hsync_d reset to 1, so a frame or line already in progress at reset release is never counted.
  - dval_d resets to 0.
- Edges: rise = in & ~d, fall = ~in & d, evaluated on the current sample. All outputs are registered: visible one cycle after the sampling edge.
- States:
  - SEEK: ignore everything until vsync rise → MEAS.
  - MEAS: accumulate; on vsync fall, evaluate the frame → MEAS (next frame needs its own vsync rise).
- In MEAS:
  - pix_cnt increments each dval_i=1 cycle.
  - On dval fall, the line closes: meas_hact ← pix_cnt (including the current cycle if dval was high), line_cnt++, pix_cnt ← 0. If the count ≠ EXP_HACT, set frame hact_err.
  - htotal counter clears on hsync rise. On every hsync rise after the first of the frame, latch meas_htotal. If the new value differs from the previous one within the same frame, set htotal_err.
  - Stray dval: dval_i=1 while vsync_i=0 sets stray_err for the next frame evaluation, in any state.
- Frame evaluation on vsync fall:
  - Close an open line first: a dval fall or vsync fall on the same cycle counts that line.
  - meas_vact ← line_cnt; vact_err = (line_cnt ≠ EXP_VACT).
  - err_flags ← {htotal_err, stray_err, vact_err, hact_err}; frame_ok ← (all 0).
  - frame_done pulses; frame_cnt++ (wraps); internal errors and counts clear.
- Lock:
  - good_cnt increments on an ok frame, saturating at LOCK_FRAMES; clears on a bad frame.
  - locked = (good_cnt == LOCK_FRAMES), updated with frame_done.
- Counters saturate at all-ones (no wrap) except frame_cnt. A saturated pix_cnt or line_cnt is flagged as a mismatch.
- Reset mid-frame: everything clears; the partial frame is discarded; return to SEEK.

Optional Feature:
- Macro: VIDEO_TIMING_ANALYZER_CSUM_EN.
- Defined: a 32-bit accumulator adds rdata_i+gdata_i+bdata_i on each dval_i=1 cycle in MEAS, modulo 2^32. It is latched to meas_csum at frame_done and cleared for the next frame.
- Undefined: no accumulator; meas_csum is tied to 0. The port is present in both builds.

Decomposition:
- Package video_timing_pkg holds:
  - state enum (SEEK, MEAS)
  - err bit index localparams (ERR_HACT=0, ERR_VACT=1, ERR_STRAY=2, ERR_HTOT=3)
  - default geometry constants (640/480)
- Sub-module sync_edge_det: registered delay plus rise/fall outputs, with a reset-value parameter. Instantiated 3x (vsync, hsync, dval).

Test Plan:
- Nominal: 480 lines × 640 dval, htotal 800, vsync window, 3 frames → frame_ok=1 each frame, meas_hact=640, meas_vact=480, meas_htotal=800, locked rises on frame 3's frame_done, frame_cnt=3.
- Short line: line 100 has 639 pixels → err_flags=4'b0001, frame_ok=0, locked drops to 0, next good frame gives good_cnt=1 and locked=0.
- Missing line: 479 lines → err_flags[1]=1, meas_vact=479.
- Stray dval: dval pulses 5 cycles while vsync_i=0 → err_flags[2]=1 at the next frame_done. htotal 800 then 801 within a frame → err_flags[3]=1.
- Reset mid-frame at line 200, with vsync_i still high at release → no frame_done until after the next vsync rise; the first reported frame has meas_vact=480.
- With VIDEO_TIMING_ANALYZER_CSUM_EN, constant pixel r=1, g=2, b=3, 640×480 frame → meas_csum=1843200. Without the macro → meas_csum=0.
